adc_reader: RTL and testbench

ADC_READER -- requirements
Module: adc_reader

---
 rtl/adc_reader_pkg.sv | 31 +++
 rtl/adc_reader_if.sv | 19 +
 rtl/adc_bcd_conv.sv | 60 ++++++
 rtl/adc_reader.sv | 142 ++++++++++++++
 tb/tb_adc_reader.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_reader_pkg.sv
// adc_reader_pkg: converter FSM states, timing defaults and BCD helper
// shared by the ADC-side and DAC-side converter blocks.
package adc_reader_pkg;

   typedef enum logic [2:0] {
      ST_GAP,
      ST_START,
      ST_WAIT_EOC,
      ST_READ,
      ST_LATCH
   } conv_state_e;

   localparam int unsigned T_GAP_DEF     = 200;
   localparam int unsigned T_WR_DEF      = 50;
   localparam int unsigned T_RD_DEF      = 30;
   localparam int unsigned T_TIMEOUT_DEF = 1000;

   localparam int CNT_W = 16;

   // One double-dabble step: add 3 to every BCD digit >= 5.
   function automatic logic [11:0] bcd_adj(input logic [11:0] v);
      logic [11:0] r;
      r = v;
      for (int i = 0; i < 3; i++) begin
         if (r[4*i +: 4] >= 4'd5)
            r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

endpackage

// File: rtl/adc_reader_if.sv
// adc_reader_if: parallel ADC bus (strobes, data, end-of-conversion).
// master = controller driving strobes, slave = ADC device.
interface adc_reader_if;
   logic       cs_n;
   logic       wr_n;
   logic       rd_n;
   logic [7:0] adc_d;
   logic       intr_n;

   modport master (
      output cs_n, wr_n, rd_n,
      input  adc_d, intr_n
   );

   modport slave (
      input  cs_n, wr_n, rd_n,
      output adc_d, intr_n
   );
endinterface

// File: rtl/adc_bcd_conv.sv
// adc_bcd_conv: sequential shift-add-3 binary to 3-digit BCD.
// Ports: clk, rst (async low), start loads din, bcd holds last result.
module adc_bcd_conv
   import adc_reader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  din,
   output logic [11:0] bcd
);

   logic        busy_q, busy_d;
   logic [3:0]  bit_q, bit_d;
   logic [7:0]  bin_q, bin_d;
   logic [11:0] acc_q, acc_d;
   logic [11:0] bcd_q, bcd_d;

   always_comb begin
      busy_d = busy_q;
      bit_d  = bit_q;
      bin_d  = bin_q;
      acc_d  = acc_q;
      bcd_d  = bcd_q;
      if (start) begin
         busy_d = 1'b1;
         bit_d  = 4'd8;
         bin_d  = din;
         acc_d  = '0;
      end else if (busy_q) begin
         acc_d = (bcd_adj(acc_q) << 1) | {11'b0, bin_q[7]};
         bin_d = {bin_q[6:0], 1'b0};
         bit_d = bit_q - 4'd1;
         // bcd output only moves once the full result is ready
         if (bit_q == 4'd1) begin
            busy_d = 1'b0;
            bcd_d  = acc_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q <= 1'b0;
         bit_q  <= '0;
         bin_q  <= '0;
         acc_q  <= '0;
         bcd_q  <= '0;
      end else begin
         busy_q <= busy_d;
         bit_q  <= bit_d;
         bin_q  <= bin_d;
         acc_q  <= acc_d;
         bcd_q  <= bcd_d;
      end
   end

   assign bcd = bcd_q;

endmodule

// File: rtl/adc_reader.sv
// adc_reader: drives a WR/RD/INTR parallel ADC, captures samples.
// Ports: clk, rst (async low), en, bus (ADC master), sample/valid/bcd/err/cnt.
module adc_reader
   import adc_reader_pkg::*;
#(
   parameter int unsigned T_GAP     = T_GAP_DEF,
   parameter int unsigned T_WR      = T_WR_DEF,
   parameter int unsigned T_RD      = T_RD_DEF,
   parameter int unsigned T_TIMEOUT = T_TIMEOUT_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   adc_reader_if.master bus,
   output logic [7:0]   sample,
   output logic         sample_valid,
   output logic [11:0]  bcd,
   output logic         timeout_err,
   output logic [15:0]  conv_cnt
);

   localparam logic [CNT_W-1:0] GAP_END = CNT_W'(T_GAP - 1);
   localparam logic [CNT_W-1:0] WR_END  = CNT_W'(T_WR - 1);
   localparam logic [CNT_W-1:0] RD_END  = CNT_W'(T_RD - 1);
   localparam logic [CNT_W-1:0] TO_END  = CNT_W'(T_TIMEOUT - 1);

   conv_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       sync_q, sync_d;
   logic             cs_n_q, cs_n_d;
   logic             wr_n_q, wr_n_d;
   logic             rd_n_q, rd_n_d;
   logic [7:0]       sample_q, sample_d;
   logic             sv_q, sv_d;
   logic             terr_q, terr_d;
   logic [15:0]      conv_cnt_q, conv_cnt_d;
   logic             intr_s;

   assign sync_d = {sync_q[0], bus.intr_n};
   assign intr_s = sync_q[1];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + 1'b1;
      sample_d   = sample_q;
      terr_d     = terr_q;
      conv_cnt_d = conv_cnt_q;
      unique case (state_q)
         ST_GAP: begin
            if (cnt_q == GAP_END) begin
               if (en) begin
                  state_d = ST_START;
                  cnt_d   = '0;
               end else begin
                  // idle: keep cnt parked so en restarts at once
                  cnt_d = cnt_q;
               end
            end
         end
         ST_START: begin
            if (cnt_q == WR_END) begin
               state_d = ST_WAIT_EOC;
               cnt_d   = '0;
            end
         end
         ST_WAIT_EOC: begin
            if (!intr_s) begin
               state_d = ST_READ;
               cnt_d   = '0;
            end else if (cnt_q == TO_END) begin
               state_d = ST_GAP;
               cnt_d   = '0;
               terr_d  = 1'b1;
            end
         end
         ST_READ: begin
            if (cnt_q == RD_END) begin
               state_d    = ST_LATCH;
               cnt_d      = '0;
               sample_d   = bus.adc_d;
               conv_cnt_d = conv_cnt_q + 16'd1;
            end
         end
         ST_LATCH: begin
            state_d = ST_GAP;
            cnt_d   = '0;
         end
         default: begin
            state_d = ST_GAP;
            cnt_d   = '0;
         end
      endcase
      // strobes registered from the next state so they line up with it
      cs_n_d = (state_d == ST_GAP) || (state_d == ST_LATCH);
      wr_n_d = (state_d != ST_START);
      rd_n_d = (state_d != ST_READ);
      sv_d   = (state_d == ST_LATCH);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_GAP;
         cnt_q      <= '0;
         sync_q     <= 2'b11;
         cs_n_q     <= 1'b1;
         wr_n_q     <= 1'b1;
         rd_n_q     <= 1'b1;
         sample_q   <= '0;
         sv_q       <= 1'b0;
         terr_q     <= 1'b0;
         conv_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sync_q     <= sync_d;
         cs_n_q     <= cs_n_d;
         wr_n_q     <= wr_n_d;
         rd_n_q     <= rd_n_d;
         sample_q   <= sample_d;
         sv_q       <= sv_d;
         terr_q     <= terr_d;
         conv_cnt_q <= conv_cnt_d;
      end
   end

   adc_bcd_conv u_bcd (
      .clk   (clk),
      .rst   (rst),
      .start (sv_q),
      .din   (sample_q),
      .bcd   (bcd)
   );

   assign bus.cs_n     = cs_n_q;
   assign bus.wr_n     = wr_n_q;
   assign bus.rd_n     = rd_n_q;
   assign sample       = sample_q;
   assign sample_valid = sv_q;
   assign timeout_err  = terr_q;
   assign conv_cnt     = conv_cnt_q;

endmodule

// File: tb/tb_adc_reader.sv
// tb_adc_reader: random ADC responses against a conversion-level model.
// Checks strobe widths, EOC latency, samples, BCD, timeout, en, reset, wrap.
module tb_adc_reader;

   localparam int T_GAP = 200;
   localparam int T_WR  = 50;
   localparam int T_RD  = 30;
   localparam int T_TO  = 1000;
   localparam int LIM   = 5000;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [7:0]  sample;
   logic        sample_valid;
   logic [11:0] bcd;
   logic        timeout_err;
   logic [15:0] conv_cnt;

   adc_reader_if bus ();

   adc_reader #(
      .T_GAP     (T_GAP),
      .T_WR      (T_WR),
      .T_RD      (T_RD),
      .T_TIMEOUT (T_TO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .bus          (bus),
      .sample       (sample),
      .sample_valid (sample_valid),
      .bcd          (bcd),
      .timeout_err  (timeout_err),
      .conv_cnt     (conv_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [7:0]  exp_sample;
   logic [15:0] exp_cnt;
   logic        exp_terr;
   int          n_ok;

   int sv_total;
   bit rule_bad = 1'b0;
   bit sv_long  = 1'b0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // negedge monitor: strobe widths, gaps, strobe rules
   initial begin
      int  wr_len;
      int  rd_len;
      int  gap_len;
      bit  gap_ok;
      logic sv_prev;
      wr_len = 0;
      rd_len = 0;
      gap_len = 0;
      gap_ok = 1'b0;
      sv_prev = 1'b0;
      sv_total = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            wr_len = 0;
            rd_len = 0;
            gap_len = 0;
            gap_ok = 1'b0;
            sv_prev = 1'b0;
            sv_total = 0;
         end else begin
            if (!bus.wr_n) wr_len++;
            else if (wr_len != 0) begin
               chk("wr_width", wr_len, T_WR);
               wr_len = 0;
            end
            if (!bus.rd_n) rd_len++;
            else if (rd_len != 0) begin
               chk("rd_width", rd_len, T_RD);
               rd_len = 0;
            end
            if (bus.cs_n) gap_len++;
            else begin
               if (gap_ok && gap_len != 0)
                  chk("gap_min", 32'(gap_len >= T_GAP), 1);
               gap_ok = 1'b1;
               gap_len = 0;
            end
            if (!bus.wr_n && !bus.rd_n) rule_bad = 1'b1;
            if (bus.cs_n && (!bus.wr_n || !bus.rd_n))
               rule_bad = 1'b1;
            if (sample_valid && sv_prev) sv_long = 1'b1;
            if (sample_valid) sv_total++;
            sv_prev = sample_valid;
         end
      end
   end

   task automatic wait_wr(input logic lvl, output int n);
      n = 0;
      while (bus.wr_n !== lvl && n < LIM) begin
         @(negedge clk);
         n++;
      end
      chk("wr_wait", bus.wr_n, lvl);
   endtask

   // ADC device + expected result of one conversion.
   // d: cycles after wr_n rises before intr_n falls.
   // early: intr_n already low from the start strobe.
   task automatic run_conv(input int d, input logic [7:0] val,
                           input bit early, input bit drop_en);
      int n;
      int w;
      wait_wr(1'b0, n);
      bus.adc_d = ~val;
      if (early) bus.intr_n = 1'b0;
      wait_wr(1'b1, n);
      w = 0;
      if (!early) begin
         repeat (d) begin
            @(negedge clk);
            w++;
         end
         bus.intr_n = 1'b0;
      end
      while (bus.rd_n && w < LIM) begin
         w++;
         @(negedge clk);
      end
      chk("eoc_wait", w, early ? 1 : d + 3);
      bus.intr_n = 1'b1;
      bus.adc_d = val;
      if (drop_en) en = 1'b0;
      n = 0;
      while (!sample_valid && n < LIM) begin
         @(negedge clk);
         n++;
      end
      chk("sv_seen", sample_valid, 1);
      bus.adc_d = 8'($urandom);
      exp_sample = val;
      exp_cnt = exp_cnt + 16'd1;
      n_ok++;
      chk("sample", sample, exp_sample);
      chk("terr", timeout_err, exp_terr);
      @(negedge clk);
      chk("sv_pulse", sample_valid, 0);
      chk("conv_cnt", conv_cnt, exp_cnt);
      repeat (9) @(negedge clk);
      chk("bcd", bcd, to_bcd(int'(val)));
   endtask

   task automatic run_timeout();
      int n;
      wait_wr(1'b0, n);
      bus.intr_n = 1'b1;
      wait_wr(1'b1, n);
      n = 0;
      while (!bus.cs_n && n < LIM) begin
         n++;
         @(negedge clk);
      end
      chk("eoc_timeout", n, T_TO);
      exp_terr = 1'b1;
      chk("terr_set", timeout_err, exp_terr);
      chk("to_sample", sample, exp_sample);
      chk("to_cnt", conv_cnt, exp_cnt);
      chk("to_nosv", sv_total, n_ok);
      wait_wr(1'b0, n);
      chk("to_restart", n, T_GAP);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit idle_bad;
      rst = 1'b0;
      en = 1'b0;
      bus.intr_n = 1'b1;
      bus.adc_d = 8'h00;
      exp_sample = 8'h00;
      exp_cnt = 16'h0000;
      exp_terr = 1'b0;
      n_ok = 0;
      repeat (3) @(negedge clk);
      chk("rst_cs", bus.cs_n, 1);
      chk("rst_wr", bus.wr_n, 1);
      chk("rst_rd", bus.rd_n, 1);
      chk("rst_sample", sample, 0);
      chk("rst_bcd", bcd, 0);
      chk("rst_cnt", conv_cnt, 0);
      rst = 1'b1;
      en = 1'b1;
      wait_wr(1'b0, n);
      chk("first_start", n, T_GAP);

      run_conv(100, 8'hC8, 1'b0, 1'b0);
      run_conv(5, 8'd255, 1'b0, 1'b0);
      run_conv(0, 8'd0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++)
         run_conv($urandom_range(0, 300), 8'($urandom),
                  $urandom_range(0, 3) == 0, 1'b0);

      run_timeout();
      run_conv($urandom_range(0, 300), 8'($urandom), 1'b0, 1'b0);

      run_conv($urandom_range(0, 300), 8'($urandom), 1'b0, 1'b1);
      idle_bad = 1'b0;
      repeat (500) begin
         @(negedge clk);
         if (!bus.cs_n || !bus.wr_n || !bus.rd_n) idle_bad = 1'b1;
      end
      chk("idle_strobes", idle_bad, 0);
      chk("idle_cnt", conv_cnt, exp_cnt);
      en = 1'b1;
      wait_wr(1'b0, n);
      chk("en_restart", n, 1);
      run_conv($urandom_range(0, 300), 8'($urandom), 1'b0, 1'b0);

      // reset in the middle of the start strobe
      wait_wr(1'b0, n);
      repeat (10) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_wr", bus.wr_n, 1);
      chk("arst_cs", bus.cs_n, 1);
      chk("arst_rd", bus.rd_n, 1);
      chk("arst_sample", sample, 0);
      chk("arst_sv", sample_valid, 0);
      chk("arst_bcd", bcd, 0);
      chk("arst_terr", timeout_err, 0);
      chk("arst_cnt", conv_cnt, 0);
      exp_sample = 8'h00;
      exp_cnt = 16'h0000;
      exp_terr = 1'b0;
      n_ok = 0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      wait_wr(1'b0, n);
      chk("rst_restart", n, T_GAP);
      run_conv($urandom_range(0, 300), 8'($urandom), 1'b0, 1'b0);

      // counter wrap: preload near the top, then two conversions
      force dut.conv_cnt_q = 16'hFFFE;
      @(negedge clk);
      release dut.conv_cnt_q;
      exp_cnt = 16'hFFFE;
      run_conv($urandom_range(0, 50), 8'($urandom), 1'b0, 1'b0);
      run_conv($urandom_range(0, 50), 8'($urandom), 1'b1, 1'b0);
      chk("wrap_zero", conv_cnt, 16'h0000);

      chk("strobe_rule", rule_bad, 0);
      chk("sv_width", sv_long, 0);
      chk("sv_count", sv_total, n_ok);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
